fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the single-cycle/multi-cycle Controller. Holds the architectural PC. Issues word fetches to instruction memory over a req/ack handshake and buffers one instruction in an instruction register. Presents OpCode/Funct to the Controller with a valid/ready handshake and accepts PC redirects (branch/jump/jr targets) from the execute side.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: holds the architectural PC, fetches words over a req/ack handshake and
// buffers one instruction for the Controller. Define MISALIGN_TRAP_EN to trap misaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_flag
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetchState_t;

  fetchState_t state;
  logic [31:0] pc;
  logic [31:0] drainAddr;
  logic        redirectMisaligned;
  logic [31:0] redirectTarget;

  always_comb begin
    redirectMisaligned = (redirect_pc[1:0] != 2'b00);
    redirectTarget     = (TRAP_EN && redirectMisaligned) ? EXC_VECTOR : redirect_pc;
  end

  // DRAIN keeps presenting the abandoned address so the memory sees a stable request until ack.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drainAddr : pc;

  assign OpCode   = inst[31:26];
  assign Funct    = inst[5:0];
  assign pc_plus4 = inst_pc + 32'd4;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drainAddr  <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (redirect_valid) begin
      // A redirect outranks ack and inst_ready: flush and retarget whatever the state.
      pc         <= redirectTarget;
      inst_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (imem_ack) begin
            state <= FETCH;
          end else begin
            state     <= DRAIN;
            drainAddr <= pc;
          end
        end
        HOLD:    state <= FETCH;
        DRAIN:   state <= DRAIN;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            pc         <= pc + 32'd4;
            inst_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_flag <= 1'b0;
    end else if (redirect_valid && redirectMisaligned) begin
      misalign_flag <= 1'b1;
    end
  end
`else
  assign misalign_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven decode vectors, hand-written handshake/redirect sequences and a
// randomized run checked against a transaction-level model of the delivered instruction stream.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0004;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] word;
    logic [5:0]  op;
    logic [5:0]  fn;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        misalign_flag;

  int nChecks = 0;
  int nFails  = 0;
  int memDelay = 0;
  bit memRandom = 1'b0;
  int waitCnt = -1;
  logic [31:0] memImage [logic [31:0]];
  vec_t vecs [4];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .OpCode(OpCode), .Funct(Funct), .inst_pc(inst_pc), .pc_plus4(pc_plus4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_flag(misalign_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (memImage.exists(a)) return memImage[a];
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory responder for the coming edge, then one clock; returns at the following negedge.
  task automatic tick();
    bit          pend;
    logic [31:0] addrBefore;
    if (reset || !imem_req) begin
      imem_ack = 1'b0;
      waitCnt  = -1;
    end else begin
      if (waitCnt < 0) waitCnt = memRandom ? int'($urandom_range(0, 3)) : memDelay;
      if (waitCnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = memWord(imem_addr);
        waitCnt    = -1;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        waitCnt--;
      end
    end
    pend       = imem_req && !imem_ack && !reset;
    addrBefore = imem_addr;
    @(posedge clk);
    @(negedge clk);
    if (pend) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_held", imem_addr, addrBefore);
    end
  endtask

  task automatic waitValid(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!inst_valid && n < limit);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_flag", 32'(misalign_flag), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int delivered;
    logic [31:0] expPc;
    logic [31:0] expAddr;
    logic        expFlag;
    logic [31:0] savedInst;
    logic [31:0] savedPc;

    vecs[0] = '{word: 32'h8C88_0004, op: 6'h23, fn: 6'h04};
    vecs[1] = '{word: 32'h0085_1020, op: 6'h00, fn: 6'h20};
    vecs[2] = '{word: 32'h0810_0000, op: 6'h02, fn: 6'h00};
    vecs[3] = '{word: 32'hFFFF_FFFF, op: 6'h3F, fn: 6'h3F};
    for (int i = 0; i < 4; i++) memImage[RESET_PC + 32'(4 * i)] = vecs[i].word;

    // Zero-wait memory, always ready: one instruction every two cycles.
    memDelay = 0;
    applyReset();
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitValid(10, n);
      check("zw_latency", 32'(n), (i == 0) ? 32'd1 : 32'd2);
      check("zw_inst_pc", inst_pc, RESET_PC + 32'(4 * i));
      check("zw_inst", inst, vecs[i].word);
      check("zw_opcode", 32'(OpCode), 32'(vecs[i].op));
      check("zw_funct", 32'(Funct), 32'(vecs[i].fn));
      check("zw_pc_plus4", pc_plus4, RESET_PC + 32'(4 * (i + 1)));
      check("zw_req_hold", 32'(imem_req), 32'd0);
    end

    // Ack delayed three cycles: request held, valid follows the ack.
    memDelay = 3;
    applyReset();
    n = 0;
    while (!inst_valid && n < 20) begin
      check("dly_req", 32'(imem_req), 32'd1);
      check("dly_addr", imem_addr, RESET_PC);
      tick();
      n++;
    end
    check("dly_latency", 32'(n), 32'd4);
    check("dly_inst", inst, vecs[0].word);

    // Consumer stalls five cycles.
    savedInst = inst;
    savedPc = inst_pc;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_inst", inst, savedInst);
      check("stall_inst_pc", inst_pc, savedPc);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_pc", imem_addr, RESET_PC + 32'd4);
    end

    // Redirect while holding an instruction.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0040_0100;
    tick();
    redirect_valid = 1'b0;
    check("hold_redir_valid", 32'(inst_valid), 32'd0);
    check("hold_redir_addr", imem_addr, 32'h0040_0100);
    memDelay = 0;
    waitValid(10, n);
    check("hold_redir_inst_pc", inst_pc, 32'h0040_0100);
    check("hold_redir_inst", inst, memWord(32'h0040_0100));

    // Redirect during an outstanding fetch: drain the old address, discard its data.
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("drain_pre_addr", imem_addr, 32'h0040_0104);
    memDelay = 2;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0040_0200;
    tick();
    redirect_valid = 1'b0;
    check("drain_addr0", imem_addr, 32'h0040_0104);
    check("drain_valid0", 32'(inst_valid), 32'd0);
    tick();
    check("drain_addr1", imem_addr, 32'h0040_0104);
    tick();
    check("drain_discard", 32'(inst_valid), 32'd0);
    check("drain_next_addr", imem_addr, 32'h0040_0200);
    check("drain_next_req", 32'(imem_req), 32'd1);
    memDelay = 0;
    tick();
    check("drain_new_valid", 32'(inst_valid), 32'd1);
    check("drain_new_inst_pc", inst_pc, 32'h0040_0200);
    check("drain_new_inst", inst, memWord(32'h0040_0200));

    // PC wraps at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    waitValid(10, n);
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    inst_ready = 1'b1;
    waitValid(10, n);
    inst_ready = 1'b0;
    check("wrap_next_pc", inst_pc, 32'h0000_0000);

    // Misaligned redirect.
    expAddr = TRAP_EN ? EXC_VECTOR : 32'h0040_0102;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0040_0102;
    tick();
    redirect_valid = 1'b0;
    check("mis_addr", imem_addr, expAddr);
    check("mis_flag", 32'(misalign_flag), 32'(TRAP_EN));
    check("mis_valid", 32'(inst_valid), 32'd0);
    waitValid(10, n);
    check("mis_inst_pc", inst_pc, expAddr);
    check("mis_flag_sticky", 32'(misalign_flag), 32'(TRAP_EN));

    // Randomized run against a stream model: deliveries follow the PC sequence from each redirect.
    memRandom = 1'b1;
    applyReset();
    expPc = RESET_PC;
    expFlag = 1'b0;
    delivered = 0;
    for (int c = 0; c < 4000; c++) begin
      bit wasValid;
      bit consume;
      bit misal;
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = RESET_PC + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      wasValid = inst_valid;
      consume = wasValid && inst_ready && !redirect_valid;
      if (consume) begin
        check("rnd_inst_pc", inst_pc, expPc);
        check("rnd_inst", inst, memWord(expPc));
        check("rnd_pc_plus4", pc_plus4, expPc + 32'd4);
        check("rnd_opcode", 32'(OpCode), 32'(memWord(expPc) >> 26));
        expPc = expPc + 32'd4;
        delivered++;
      end
      savedInst = inst;
      savedPc = inst_pc;
      if (redirect_valid) begin
        misal = (redirect_pc[1:0] != 2'b00);
        expPc = (TRAP_EN && misal) ? EXC_VECTOR : redirect_pc;
        if (TRAP_EN && misal) expFlag = 1'b1;
      end
      tick();
      check("rnd_flag", 32'(misalign_flag), 32'(expFlag));
      if (redirect_valid) begin
        check("rnd_flush", 32'(inst_valid), 32'd0);
      end else if (wasValid && !consume) begin
        check("rnd_hold_valid", 32'(inst_valid), 32'd1);
        check("rnd_hold_inst", inst, savedInst);
        check("rnd_hold_pc", inst_pc, savedPc);
      end
    end
    check("rnd_progress", 32'(delivered > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
